igr_wadj_fc_ctrl: RTL and testbench

Ingress flow-control and drop controller for the packet-switch width adjuster. It sits between the ingress port and the width-adjust buffer as a single registered beat stage. It makes a per-packet pass/drop decision at SOP from the buffer fill level and `cfg_drop_threshold`. It also drives a hysteretic RX pause request from `cfg_rx_pause_en` and `cfg_rx_pause_threshold`, the outputs of the wadj CSR block.

---
 rtl/igr_wadj_fc_ctrl.sv | 147 ++++++++++++++
 tb/tb_igr_wadj_fc_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/igr_wadj_fc_ctrl.sv
// Ingress flow-control/drop stage for the width adjuster: one registered beat stage,
// per-packet SOP drop decision and hysteretic RX pause. Define IGR_WADJ_FC_STATS_EN for counters.
module igr_wadj_fc_ctrl #(
  parameter int DATA_WIDTH    = 512,
  parameter int FILL_WIDTH    = 16,
  parameter int PAUSE_HYST    = 16,
  parameter int PAUSE_MIN_CYC = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_rx_pause_en,
  input  logic [15:0]           cfg_rx_pause_threshold,
  input  logic [15:0]           cfg_drop_threshold,
  input  logic [FILL_WIDTH-1:0] fifo_fill,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  rx_pause_req,
  output logic [CNT_WIDTH-1:0]  stat_drop_pkts,
  output logic [CNT_WIDTH-1:0]  stat_pause_evts
);

  typedef enum logic [1:0] {PKT_IDLE, PKT_PASS, PKT_DROP} pkt_state_t;
  typedef enum logic       {PAUSE_XON, PAUSE_XOFF}        pause_state_t;

  localparam int HOLD_W = (PAUSE_MIN_CYC > 1) ? $clog2(PAUSE_MIN_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(PAUSE_MIN_CYC - 1);
  localparam logic [16:0]       HYST17    = 17'(PAUSE_HYST);

  pkt_state_t        pkt_state;
  pause_state_t      pause_state;
  logic [HOLD_W-1:0] hold_cnt;

  logic [15:0] fill16;
  logic        drop_hit;
  logic        drop_beat;
  logic        in_accept;
  logic        load;
  logic        pause_set;
  logic [16:0] rel_diff;
  logic [15:0] rel_level;

  assign fill16   = 16'(fifo_fill);
  assign drop_hit = (cfg_drop_threshold != 16'd0) && (fill16 >= cfg_drop_threshold);

  // An SOP carries its own fresh decision; any other beat follows the packet state.
  assign drop_beat = in_sop ? drop_hit : (pkt_state == PKT_DROP);
  assign in_ready  = drop_beat | out_ready | ~out_valid;
  assign in_accept = in_valid & in_ready;
  assign load      = in_accept & ~drop_beat & (in_sop | (pkt_state == PKT_PASS));

  // Pause release level, clamped at zero when the hysteresis exceeds the threshold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rel_level = '0;
    rel_diff  = {1'b0, cfg_rx_pause_threshold} - HYST17;
    if (!rel_diff[16]) rel_level = rel_diff[15:0];
  end

  assign pause_set = cfg_rx_pause_en && (pause_state == PAUSE_XON) &&
                     (fill16 >= cfg_rx_pause_threshold);

  // NOTE: out_data is a single datapath register with a defined reset value; only
  // deep storage arrays are left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sop   <= in_sop;
      out_eop   <= in_eop;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state <= PKT_IDLE;
    end else if (in_accept) begin
      if (in_sop) begin
        if (in_eop)        pkt_state <= PKT_IDLE;
        else if (drop_hit) pkt_state <= PKT_DROP;
        else               pkt_state <= PKT_PASS;
      end else if (in_eop) begin
        pkt_state <= PKT_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_state <= PAUSE_XON;
      hold_cnt    <= '0;
    end else if (!cfg_rx_pause_en) begin
      pause_state <= PAUSE_XON;
      hold_cnt    <= '0;
    end else begin
      case (pause_state)
        PAUSE_XON: begin
          if (pause_set) begin
            pause_state <= PAUSE_XOFF;
            hold_cnt    <= HOLD_INIT;
          end
        end
        PAUSE_XOFF: begin
          if (hold_cnt != '0)          hold_cnt    <= hold_cnt - 1'b1;
          else if (fill16 < rel_level) pause_state <= PAUSE_XON;
        end
        default: pause_state <= PAUSE_XON;
      endcase
    end
  end

  assign rx_pause_req = (pause_state == PAUSE_XOFF);

`ifdef IGR_WADJ_FC_STATS_EN
  logic drop_evt;
  assign drop_evt = in_accept & in_sop & drop_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_drop_pkts  <= '0;
      stat_pause_evts <= '0;
    end else begin
      if (drop_evt && (stat_drop_pkts != '1))   stat_drop_pkts  <= stat_drop_pkts + 1'b1;
      if (pause_set && (stat_pause_evts != '1)) stat_pause_evts <= stat_pause_evts + 1'b1;
    end
  end
`else
  assign stat_drop_pkts  = '0;
  assign stat_pause_evts = '0;
`endif

endmodule

// File: tb/tb_igr_wadj_fc_ctrl.sv
// Scoreboard bench for igr_wadj_fc_ctrl: stimulus pushes expected egress beats,
// a negedge monitor pops and compares them; side-band outputs are checked inline.
module tb_igr_wadj_fc_ctrl;

`ifdef IGR_WADJ_FC_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [511:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_rx_pause_en;
  logic [15:0]  cfg_rx_pause_threshold;
  logic [15:0]  cfg_drop_threshold;
  logic [15:0]  fifo_fill;
  logic         in_valid, in_sop, in_eop;
  logic [511:0] in_data;
  logic         in_ready;
  logic         out_valid, out_sop, out_eop;
  logic [511:0] out_data;
  logic         out_ready;
  logic         rx_pause_req;
  logic [31:0]  stat_drop_pkts;
  logic [31:0]  stat_pause_evts;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  igr_wadj_fc_ctrl #(
    .DATA_WIDTH(512), .FILL_WIDTH(16), .PAUSE_HYST(16), .PAUSE_MIN_CYC(64), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_rx_pause_en(cfg_rx_pause_en),
    .cfg_rx_pause_threshold(cfg_rx_pause_threshold),
    .cfg_drop_threshold(cfg_drop_threshold),
    .fifo_fill(fifo_fill),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_ready(out_ready),
    .rx_pause_req(rx_pause_req),
    .stat_drop_pkts(stat_drop_pkts),
    .stat_pause_evts(stat_pause_evts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [527:0] act, input logic [527:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat until accepted; 'pass' says whether it must appear on egress.
  task automatic send(input logic sop, input logic eop, input logic [511:0] data,
                      input logic pass);
    bit acc    = 1'b0;
    int waited = 0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = data;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && pass) sb.push_back('{sop, eop, data});
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: beat %0h not accepted within 50 cycles", data);
    end else if (pass) begin
      check("latency_valid", 528'(out_valid), 528'(1));
      check("latency_data", 528'(out_data), 528'(data));
    end else begin
      check("drop_immediate_accept", 528'(waited), 528'(1));
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Egress monitor: every emitted beat must match the head of the scoreboard.
  initial begin
    beat_t exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          exp = sb.pop_front();
          check("egress_beat", 528'({out_sop, out_eop, out_data}), 528'(exp));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cfg_rx_pause_en = 1'b0; cfg_rx_pause_threshold = 16'd0; cfg_drop_threshold = 16'd0;
    fifo_fill = 16'd0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    out_ready = 1'b1;

    // Reset state
    #23;
    check("rst_out_valid", 528'(out_valid), 528'(0));
    check("rst_out_data", 528'(out_data), 528'(0));
    check("rst_in_ready", 528'(in_ready), 528'(1));
    check("rst_pause", 528'(rx_pause_req), 528'(0));
    check("rst_stats", 528'({stat_drop_pkts, stat_pause_evts}), 528'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Pass-through, back-to-back 4-beat packet
    send(1'b1, 1'b0, 512'h1001, 1'b1);
    send(1'b0, 1'b0, 512'h1002, 1'b1);
    send(1'b0, 1'b0, 512'h1003, 1'b1);
    send(1'b0, 1'b1, 512'h1004, 1'b1);
    idle(2);
    check("pass_no_drops", 528'(stat_drop_pkts), 528'(0));

    // Drop on SOP at fill == threshold, no egress credit
    cfg_drop_threshold = 16'd100; fifo_fill = 16'd100; out_ready = 1'b0;
    send(1'b1, 1'b0, 512'hD1, 1'b0);
    check("drop_no_valid0", 528'(out_valid), 528'(0));
    fifo_fill = 16'd0;
    send(1'b0, 1'b0, 512'hD2, 1'b0);
    check("drop_no_valid1", 528'(out_valid), 528'(0));
    send(1'b0, 1'b1, 512'hD3, 1'b0);
    check("drop_no_valid2", 528'(out_valid), 528'(0));
    check("drop_count1", 528'(stat_drop_pkts), 528'(STATS_ON * 1));
    out_ready = 1'b1; fifo_fill = 16'd99;
    send(1'b1, 1'b0, 512'hA1, 1'b1);
    send(1'b0, 1'b1, 512'hA2, 1'b1);
    idle(2);

    // Dropping must not disturb a beat held in the output register
    out_ready = 1'b0; fifo_fill = 16'd0;
    send(1'b1, 1'b1, 512'hB0, 1'b1);
    fifo_fill = 16'd100;
    send(1'b1, 1'b0, 512'hC1, 1'b0);
    send(1'b0, 1'b1, 512'hC2, 1'b0);
    check("held_valid", 528'(out_valid), 528'(1));
    check("held_data", 528'(out_data), 528'(512'hB0));
    out_ready = 1'b1; fifo_fill = 16'd0;
    idle(2);
    check("drop_count2", 528'(stat_drop_pkts), 528'(STATS_ON * 2));

    // Backpressure: out_ready 1,0,0,1 during a 3-beat packet
    cfg_drop_threshold = 16'd0;
    fork
      begin
        send(1'b1, 1'b0, 512'hE0, 1'b1);
        send(1'b0, 1'b0, 512'hE1, 1'b1);
        send(1'b0, 1'b1, 512'hE2, 1'b1);
      end
      begin
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("bp_in_ready_low", 528'(in_ready), 528'(0));
          check("bp_hold_valid", 528'(out_valid), 528'(1));
          check("bp_hold_beat", 528'({out_sop, out_eop, out_data}), 528'({2'b10, 512'hE0}));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(2);

    // SOP while in DROP takes a new decision
    cfg_drop_threshold = 16'd100; fifo_fill = 16'd100;
    send(1'b1, 1'b0, 512'hF1, 1'b0);
    send(1'b0, 1'b0, 512'hF2, 1'b0);
    fifo_fill = 16'd50;
    send(1'b1, 1'b0, 512'hF3, 1'b1);
    send(1'b0, 1'b1, 512'hF4, 1'b1);
    idle(2);
    check("drop_count3", 528'(stat_drop_pkts), 528'(STATS_ON * 3));

    // Pause hysteresis: threshold 200, release below 184, hold 64 cycles
    cfg_drop_threshold = 16'd0; fifo_fill = 16'd0;
    cfg_rx_pause_en = 1'b1; cfg_rx_pause_threshold = 16'd200;
    idle(1);
    check("pause_idle_low", 528'(rx_pause_req), 528'(0));
    fifo_fill = 16'd200;
    check("pause_not_yet", 528'(rx_pause_req), 528'(0));
    idle(1);
    check("pause_assert", 528'(rx_pause_req), 528'(1));
    for (int k = 2; k <= 64; k++) begin
      idle(1);
      check("pause_min_hold", 528'(rx_pause_req), 528'(1));
      if (k == 5) fifo_fill = 16'd150;
    end
    fifo_fill = 16'd190;
    idle(1);
    check("pause_hyst_190", 528'(rx_pause_req), 528'(1));
    fifo_fill = 16'd184;
    idle(1);
    check("pause_hyst_184", 528'(rx_pause_req), 528'(1));
    fifo_fill = 16'd183;
    idle(1);
    check("pause_release_183", 528'(rx_pause_req), 528'(0));
    check("pause_evts1", 528'(stat_pause_evts), 528'(STATS_ON * 1));

    // Clearing the enable releases pause with the hold counter still running
    fifo_fill = 16'd200;
    idle(1);
    check("pause_reassert", 528'(rx_pause_req), 528'(1));
    cfg_rx_pause_en = 1'b0;
    idle(1);
    check("pause_en_clear", 528'(rx_pause_req), 528'(0));
    check("pause_evts2", 528'(stat_pause_evts), 528'(STATS_ON * 2));
    fifo_fill = 16'd0;
    idle(1);

    // Reset mid-packet: output flushed at once, trailing beats discarded
    send(1'b1, 1'b0, 512'h51, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 528'(out_valid), 528'(0));
    check("midrst_in_ready", 528'(in_ready), 528'(1));
    check("midrst_stats", 528'({stat_drop_pkts, stat_pause_evts}), 528'(0));
    sb.delete();
    #1;
    rst_n = 1'b1;
    send(1'b0, 1'b0, 512'h52, 1'b0);
    check("trail_discard0", 528'(out_valid), 528'(0));
    send(1'b0, 1'b1, 512'h53, 1'b0);
    check("trail_discard1", 528'(out_valid), 528'(0));
    send(1'b1, 1'b1, 512'h54, 1'b1);
    idle(3);

    check("scoreboard_drained", 528'(sb.size()), 528'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
